// File: rtl/matvec_mac.sv
// matvec_mac: sequential N x N matrix by N-vector multiplier.
// The matrix lives in a register file written through a simple port; a vector
// is captured on a valid/ready handshake, one MAC per row walks the columns
// for N cycles, and the result is held on out_data until the consumer accepts.
module matvec_mac #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter bit SIGNED = 1'b0,
  parameter int ACCW   = 2*DW+$clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mat_we,
  input  logic [$clog2(N*N)-1:0] mat_addr,
  input  logic [DW-1:0]          mat_wdata,
  input  logic                   vec_valid,
  output logic                   vec_ready,
  input  logic [N*DW-1:0]        vec_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACCW-1:0]      out_data,
  output logic                   busy
);

  localparam int AW = $clog2(N*N);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DW-1:0]     mat_r [N*N];
  logic [N*DW-1:0]   vec_r;
  logic [ACCW-1:0]   acc_r [N];
  logic [CW-1:0]     col_r;
  state_t            state_r;
  logic              vec_ready_r;
  logic              out_valid_r;
  logic              busy_r;
  logic [N*ACCW-1:0] out_data_r;

  logic [DW-1:0]     m_sel_s   [N];
  logic [DW-1:0]     v_sel_s;
  logic [ACCW-1:0]   acc_nxt_s [N];

  // Widen one operand to accumulator width, sign- or zero-extending by mode.
  function automatic logic [ACCW-1:0] ext(input logic [DW-1:0] x);
    logic [ACCW-1:0] y;
    if (SIGNED) begin
      y = {{(ACCW-DW){x[DW-1]}}, x};
    end else begin
      y = {{(ACCW-DW){1'b0}}, x};
    end
    return y;
  endfunction

  // Matrix register file: writes only land while no product is in flight.
  // An address beyond N*N-1 matches no element and is therefore ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N*N; i++) mat_r[i] <= '0;
    end else if (mat_we && !busy_r) begin
      for (int i = 0; i < N*N; i++) begin
        if (mat_addr == AW'(i)) mat_r[i] <= mat_wdata;
      end
    end
  end

  // Column select and per-row multiply-accumulate for the current column.
  // Arithmetic is modulo 2^ACCW, which gives exact two's complement sums.
  always_comb begin
    v_sel_s = '0;
    for (int r = 0; r < N; r++) m_sel_s[r] = '0;
    for (int c = 0; c < N; c++) begin
      v_sel_s = (col_r == CW'(c)) ? vec_r[c*DW +: DW] : v_sel_s;
      for (int r = 0; r < N; r++) begin
        m_sel_s[r] = (col_r == CW'(c)) ? mat_r[r*N+c] : m_sel_s[r];
      end
    end
    for (int r = 0; r < N; r++) begin
      acc_nxt_s[r] = acc_r[r] + ext(m_sel_s[r]) * ext(v_sel_s);
    end
  end

  // Control FSM with registered handshake flags and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      vec_r       <= '0;
      col_r       <= '0;
      vec_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= '0;
      for (int r = 0; r < N; r++) acc_r[r] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (vec_valid) begin
            vec_r       <= vec_data;
            col_r       <= '0;
            vec_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_MAC;
            for (int r = 0; r < N; r++) acc_r[r] <= '0;
          end
        end
        ST_MAC: begin
          for (int r = 0; r < N; r++) acc_r[r] <= acc_nxt_s[r];
          col_r <= col_r + CW'(1);
          if (col_r == CW'(N-1)) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            for (int r = 0; r < N; r++) out_data_r[r*ACCW +: ACCW] <= acc_nxt_s[r];
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            vec_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          vec_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign vec_ready = vec_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_matvec_mac.sv
// Testbench for matvec_mac: table vectors, hand sequences for handshake and
// reset corners, and random products against an arithmetic reference model.
module tb_matvec_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Shared stimulus for the two N=4, DW=16 instances (unsigned and signed)
  logic         mat_we = 1'b0;
  logic [3:0]   mat_addr = 4'd0;
  logic [15:0]  mat_wdata = 16'd0;
  logic         vec_valid = 1'b0;
  logic [63:0]  vec_data = 64'd0;
  logic         out_ready = 1'b0;
  logic         a_vec_ready, a_out_valid, a_busy;
  logic [135:0] a_out_data;
  logic         b_vec_ready, b_out_valid, b_busy;
  logic [135:0] b_out_data;

  // N=3, DW=8, signed instance
  logic         c_mat_we = 1'b0;
  logic [3:0]   c_mat_addr = 4'd0;
  logic [7:0]   c_mat_wdata = 8'd0;
  logic         c_vec_valid = 1'b0;
  logic [23:0]  c_vec_data = 24'd0;
  logic         c_out_ready = 1'b0;
  logic         c_vec_ready, c_out_valid, c_busy;
  logic [53:0]  c_out_data;

  int tests = 0;
  int fails = 0;
  int lat;
  logic [15:0]  mdl_m [16];
  logic [135:0] hold;

  typedef struct {
    logic [63:0]  v;
    logic [135:0] eu;
    logic [135:0] es;
  } vec_t;
  vec_t tab [6];

  matvec_mac #(.N(4), .DW(16), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
    .vec_valid(vec_valid), .vec_ready(a_vec_ready), .vec_data(vec_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .busy(a_busy));

  matvec_mac #(.N(4), .DW(16), .SIGNED(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
    .vec_valid(vec_valid), .vec_ready(b_vec_ready), .vec_data(vec_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .busy(b_busy));

  matvec_mac #(.N(3), .DW(8), .SIGNED(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .mat_we(c_mat_we), .mat_addr(c_mat_addr), .mat_wdata(c_mat_wdata),
    .vec_valid(c_vec_valid), .vec_ready(c_vec_ready), .vec_data(c_vec_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pv(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  function automatic logic [135:0] pk4(input int e0, input int e1, input int e2, input int e3);
    return {34'(e3), 34'(e2), 34'(e1), 34'(e0)};
  endfunction

  // Reference: plain integer dot products of each matrix row with the vector
  function automatic logic [135:0] model(input logic [63:0] v, input bit sgn);
    logic [135:0] res;
    logic signed [15:0] tm, tv;
    longint s, a, b;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int c = 0; c < 4; c++) begin
        tm = mdl_m[r*4+c];
        tv = v[c*16 +: 16];
        if (sgn) begin
          a = tm;
          b = tv;
        end else begin
          a = longint'(mdl_m[r*4+c]);
          b = longint'(v[c*16 +: 16]);
        end
        s = s + a * b;
      end
      res[r*34 +: 34] = s[33:0];
    end
    return res;
  endfunction

  task automatic write_mat(input int addr, input logic [15:0] data);
    mat_we = 1'b1;
    mat_addr = 4'(addr);
    mat_wdata = data;
    @(negedge clk);
    mat_we = 1'b0;
    mdl_m[addr] = data;
  endtask

  task automatic wait_valid();
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Offer a vector, check latency and both results, then complete the handshake
  task automatic run_vec(input logic [63:0] v, input logic [135:0] eu, input logic [135:0] es, input string tag);
    vec_valid = 1'b1;
    vec_data = v;
    check({tag, " vec_ready"}, 136'(a_vec_ready), 136'(1));
    @(negedge clk);
    vec_valid = 1'b0;
    mat_we = 1'b0;
    check({tag, " busy"}, 136'(a_busy), 136'(1));
    wait_valid();
    check({tag, " latency"}, 136'(lat), 136'(4));
    check({tag, " unsigned out"}, a_out_data, eu);
    check({tag, " signed out"}, b_out_data, es);
    check({tag, " signed valid"}, 136'(b_out_valid), 136'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid drop"}, 136'(a_out_valid), 136'(0));
    check({tag, " ready back"}, 136'(a_vec_ready), 136'(1));
  endtask

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 16; i++) mdl_m[i] = 16'd0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst vec_ready", 136'(a_vec_ready), 136'(1));
    check("rst out_valid", 136'(a_out_valid), 136'(0));
    check("rst busy", 136'(a_busy), 136'(0));
    check("rst out_data", a_out_data, 136'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // N=3 signed: identity times {-5, 7, -128}
    for (int i = 0; i < 3; i++) begin
      c_mat_we = 1'b1;
      c_mat_addr = 4'(i*4);
      c_mat_wdata = 8'd1;
      @(negedge clk);
    end
    c_mat_we = 1'b0;
    check("n3 vec_ready", 136'(c_vec_ready), 136'(1));
    c_vec_data = {8'h80, 8'h07, 8'hFB};
    c_vec_valid = 1'b1;
    @(negedge clk);
    c_vec_valid = 1'b0;
    lat = 0;
    while (!c_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("n3 latency", 136'(lat), 136'(3));
    check("n3 out", 136'(c_out_data), 136'({18'h3FF80, 18'h00007, 18'h3FFFB}));
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    check("n3 ready back", 136'(c_vec_ready), 136'(1));

    // Table-driven vectors against the reference matrix
    tab[0] = '{pv(2, 5, 3, 1), pk4(16, 64, 23, 47), pk4(16, 64, 23, 47)};
    tab[1] = '{pv(0, 0, 0, 0), pk4(0, 0, 0, 0), pk4(0, 0, 0, 0)};
    tab[2] = '{pv(1, 0, 0, 0), pk4(1, 5, 1, 4), pk4(1, 5, 1, 4)};
    tab[3] = '{pv(0, 0, 0, 1), pk4(3, 3, 2, 5), pk4(3, 3, 2, 5)};
    tab[4] = '{pv(65535, 0, 0, 0), pk4(65535, 327675, 65535, 262140), pk4(-1, -5, -1, -4)};
    tab[5] = '{pv(1, 1, 1, 1), pk4(7, 21, 8, 17), pk4(7, 21, 8, 17)};
    begin
      int rows [16] = '{1, 1, 2, 3, 5, 6, 7, 3, 1, 2, 3, 2, 4, 5, 3, 5};
      for (int i = 0; i < 16; i++) write_mat(i, 16'(rows[i]));
    end
    for (int t = 0; t < 6; t++) run_vec(tab[t].v, tab[t].eu, tab[t].es, $sformatf("tab%0d", t));

    // Matrix write and vector accept on the same edge: the write is seen
    mat_we = 1'b1;
    mat_addr = 4'd0;
    mat_wdata = 16'd9;
    mdl_m[0] = 16'd9;
    v = pv(1, 0, 0, 0);
    run_vec(v, model(v, 1'b0), model(v, 1'b1), "simul");
    check("simul elem0", 136'(a_out_data[33:0]), 136'(9));

    // Backpressure: hold result while inputs toggle, then one handshake
    v = pv(2, 5, 3, 1);
    vec_valid = 1'b1;
    vec_data = v;
    @(negedge clk);
    vec_valid = 1'b0;
    wait_valid();
    check("bp latency", 136'(lat), 136'(4));
    hold = model(v, 1'b0);
    check("bp first out", a_out_data, hold);
    for (int i = 0; i < 10; i++) begin
      vec_valid = (i % 2 == 1);
      vec_data = pv(7, 7, 7, 7);
      mat_we = (i % 2 == 0);
      mat_addr = 4'd0;
      mat_wdata = 16'h1234;
      @(negedge clk);
      check("bp out stable", a_out_data, hold);
      check("bp vec_ready low", 136'(a_vec_ready), 136'(0));
      check("bp valid held", 136'(a_out_valid), 136'(1));
    end
    vec_valid = 1'b0;
    mat_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp valid drop", 136'(a_out_valid), 136'(0));
    check("bp ready back", 136'(a_vec_ready), 136'(1));
    @(negedge clk);
    check("bp idle", 136'(a_busy), 136'(0));
    check("bp out kept", a_out_data, hold);
    v = pv(1, 0, 0, 0);
    run_vec(v, model(v, 1'b0), model(v, 1'b1), "bp matrix");

    // Width extremes
    for (int i = 0; i < 16; i++) write_mat(i, 16'hFFFF);
    run_vec(64'hFFFF_FFFF_FFFF_FFFF, {4{34'h3_FFF8_0004}}, {4{34'd4}}, "extreme");

    // Random matrices and vectors against the model
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) write_mat(i, 16'($urandom));
      v = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      run_vec(v, model(v, 1'b0), model(v, 1'b1), $sformatf("rand%0d", it));
    end

    // Reset two cycles into MAC: abandon, clear matrix
    vec_valid = 1'b1;
    vec_data = pv(1, 2, 3, 4);
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 136'(a_out_valid), 136'(0));
    check("midrst vec_ready", 136'(a_vec_ready), 136'(1));
    check("midrst busy", 136'(a_busy), 136'(0));
    check("midrst out_data", a_out_data, 136'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mdl_m[i] = 16'd0;
    @(negedge clk);
    check("midrst no valid", 136'(a_out_valid), 136'(0));
    run_vec(pv(3, 4, 5, 6), 136'(0), 136'(0), "after rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
